encod4to2_ot: RTL and testbench

ENCOD4TO2_OT -- requirements
Module: encod4to2_ot

---
 rtl/encod4to2_ot.sv | 101 ++++++++++
 tb/tb_encod4to2_ot.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/encod4to2_ot.sv
// Registered 4-to-2 priority encoder with valid/err flags and a saturating
// count of multi-hot samples. Arbitration direction is set by PRIORITY_HIGH.
module encod4to2_ot #(
  parameter int PRIORITY_HIGH = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             D0,
  input  logic             D1,
  input  logic             D2,
  input  logic             D3,
  output logic             Y1,
  output logic             Y0,
  output logic             valid,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [1:0] enc_high(input logic [3:0] d);
    logic [1:0] idx;
    casez (d)
      4'b1???: idx = 2'd3;
      4'b01??: idx = 2'd2;
      4'b001?: idx = 2'd1;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [1:0] enc_low(input logic [3:0] d);
    logic [1:0] idx;
    casez (d)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  logic [3:0]       d_s;
  logic [1:0]       idx_s;
  logic             any_s;
  logic             multi_s;
  logic [1:0]       idx_r;
  logic             valid_r;
  logic             err_r;
  logic [CNT_W-1:0] cnt_r;

  assign d_s = {D3, D2, D1, D0};

  // Decode the sampled request lines into winner index and flags.
  always_comb begin
    idx_s   = 2'd0;
    any_s   = 1'b0;
    multi_s = 1'b0;
    if (PRIORITY_HIGH != 0) begin
      idx_s = enc_high(d_s);
    end else begin
      idx_s = enc_low(d_s);
    end
    any_s   = (d_s != 4'd0);
    // Clearing the lowest set bit leaves something only when two or more are set.
    multi_s = ((d_s & (d_s - 4'd1)) != 4'd0);
  end

  // Output registers and saturating error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r   <= 2'd0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (en) begin
        valid_r <= any_s;
        err_r   <= multi_s;
        if (any_s) begin
          idx_r <= idx_s;
        end
      end
      if (clr) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (en && multi_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign Y1      = idx_r[1];
  assign Y0      = idx_r[0];
  assign valid   = valid_r;
  assign err     = err_r;
  assign err_cnt = cnt_r;

endmodule

// File: tb/tb_encod4to2_ot.sv
// Directed bench: a high-priority/8-bit-counter instance and a low-priority/
// 2-bit-counter instance share the same stimulus.
module tb_encod4to2_ot;

  logic clk = 1'b0;
  logic rst_n, en, clr;
  logic [3:0] d;
  logic h_y1, h_y0, h_valid, h_err;
  logic l_y1, l_y0, l_valid, l_err;
  logic [7:0] h_cnt;
  logic [1:0] l_cnt;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  encod4to2_ot #(.PRIORITY_HIGH(1), .CNT_W(8)) dut_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .Y1(h_y1), .Y0(h_y0), .valid(h_valid), .err(h_err), .err_cnt(h_cnt)
  );

  encod4to2_ot #(.PRIORITY_HIGH(0), .CNT_W(2)) dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .Y1(l_y1), .Y0(l_y0), .valid(l_valid), .err(l_err), .err_cnt(l_cnt)
  );

  // {Y1,Y0,valid,err} per instance
  wire [3:0] h_out = {h_y1, h_y0, h_valid, h_err};
  wire [3:0] l_out = {l_y1, l_y0, l_valid, l_err};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; d = 4'b1111;
    step();
    n_checks++;
    if (h_out !== 4'b0000) begin n_fail++; $display("FAIL reset_hi_out: got %b expected %b", h_out, 4'b0000); end
    n_checks++;
    if (l_out !== 4'b0000) begin n_fail++; $display("FAIL reset_lo_out: got %b expected %b", l_out, 4'b0000); end
    n_checks++;
    if (h_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_hi_cnt: got %0d expected 0", h_cnt); end
    n_checks++;
    if (l_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_lo_cnt: got %0d expected 0", l_cnt); end
    rst_n = 1'b1; d = 4'b0000;
  endtask

  task automatic test_one_hot();
    logic [3:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      d = 4'b0001 << i;
      step();
      exp_v = {i[1:0], 2'b10};
      n_checks++;
      if (h_out !== exp_v) begin n_fail++; $display("FAIL onehot_hi[%0d]: got %b expected %b", i, h_out, exp_v); end
      n_checks++;
      if (l_out !== exp_v) begin n_fail++; $display("FAIL onehot_lo[%0d]: got %b expected %b", i, l_out, exp_v); end
    end
    n_checks++;
    if (h_cnt !== 8'd0) begin n_fail++; $display("FAIL onehot_cnt: got %0d expected 0", h_cnt); end
  endtask

  task automatic test_multi_hot();
    d = 4'b0101;
    step();
    n_checks++;
    if (h_out !== 4'b1011) begin n_fail++; $display("FAIL multi_hi: got %b expected %b", h_out, 4'b1011); end
    n_checks++;
    if (l_out !== 4'b0011) begin n_fail++; $display("FAIL multi_lo: got %b expected %b", l_out, 4'b0011); end
    n_checks++;
    if (h_cnt !== 8'd1) begin n_fail++; $display("FAIL multi_hi_cnt: got %0d expected 1", h_cnt); end
    n_checks++;
    if (l_cnt !== 2'd1) begin n_fail++; $display("FAIL multi_lo_cnt: got %0d expected 1", l_cnt); end
  endtask

  task automatic test_idle();
    d = 4'b0010;
    step();
    d = 4'b0000;
    step();
    n_checks++;
    if (h_out !== 4'b0100) begin n_fail++; $display("FAIL idle_hi: got %b expected %b", h_out, 4'b0100); end
    n_checks++;
    if (l_out !== 4'b0100) begin n_fail++; $display("FAIL idle_lo: got %b expected %b", l_out, 4'b0100); end
    n_checks++;
    if (h_cnt !== 8'd1) begin n_fail++; $display("FAIL idle_cnt: got %0d expected 1", h_cnt); end
  endtask

  task automatic test_hold();
    d = 4'b0010;
    step();
    en = 1'b0; d = 4'b1000;
    step();
    n_checks++;
    if (h_out !== 4'b0110) begin n_fail++; $display("FAIL hold_hi: got %b expected %b", h_out, 4'b0110); end
    d = 4'b1111;
    step();
    n_checks++;
    if (h_out !== 4'b0110) begin n_fail++; $display("FAIL hold_hi_multi: got %b expected %b", h_out, 4'b0110); end
    n_checks++;
    if (h_cnt !== 8'd1) begin n_fail++; $display("FAIL hold_cnt: got %0d expected 1", h_cnt); end
    en = 1'b1; d = 4'b1000;
    step();
    n_checks++;
    if (h_out !== 4'b1110) begin n_fail++; $display("FAIL hold_release: got %b expected %b", h_out, 4'b1110); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_l [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    clr = 1'b1; d = 4'b0000;
    step();
    n_checks++;
    if (h_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_clr_hi: got %0d expected 0", h_cnt); end
    clr = 1'b0; d = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (l_cnt !== exp_l[i]) begin n_fail++; $display("FAIL sat_lo[%0d]: got %0d expected %0d", i, l_cnt, exp_l[i]); end
      n_checks++;
      if (h_cnt !== 8'(i + 1)) begin n_fail++; $display("FAIL sat_hi[%0d]: got %0d expected %0d", i, h_cnt, i + 1); end
    end
    clr = 1'b1;
    step();
    n_checks++;
    if (l_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_prio_lo: got %0d expected 0", l_cnt); end
    n_checks++;
    if (h_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_prio_hi: got %0d expected 0", h_cnt); end
    n_checks++;
    if (l_out !== 4'b0011) begin n_fail++; $display("FAIL clr_lo_out: got %b expected %b", l_out, 4'b0011); end
    clr = 1'b0;
    step();
    en = 1'b0; clr = 1'b1;
    step();
    n_checks++;
    if (h_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_no_en: got %0d expected 0", h_cnt); end
    en = 1'b1; clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    d = 4'b0100;
    step();
    d = 4'b1111;
    step();
    n_checks++;
    if (h_cnt !== 8'd1) begin n_fail++; $display("FAIL mid_pre_cnt: got %0d expected 1", h_cnt); end
    rst_n = 1'b0; d = 4'b1000;
    step();
    n_checks++;
    if (h_out !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_out: got %b expected %b", h_out, 4'b0000); end
    n_checks++;
    if (h_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d expected 0", h_cnt); end
    step();
    n_checks++;
    if (l_out !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_hold: got %b expected %b", l_out, 4'b0000); end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (h_out !== 4'b1110) begin n_fail++; $display("FAIL mid_resume: got %b expected %b", h_out, 4'b1110); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; d = 4'b0000;
    test_reset();
    test_one_hot();
    test_multi_hot();
    test_idle();
    test_hold();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
